// File: rtl/lock_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lock_sequencer_if : encoder/button inputs and display/status outputs
// Rev 1.0
// ----------------------------------------------------------------------------
interface lock_sequencer_if;
  logic [3:0] enc;
  logic [2:0] pb_press_type;
  logic [3:0] display_value;
  logic [2:0] display_select;
  logic       unlocked;
  logic       alarm;

  modport master (
    output enc, pb_press_type,
    input  display_value, display_select, unlocked, alarm
  );

  modport slave (
    input  enc, pb_press_type,
    output display_value, display_select, unlocked, alarm
  );
endinterface
`default_nettype wire

// File: rtl/lock_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lock_sequencer : combination-lock controller with retry count and lockout.
// Optional code programming from OPEN when LOCK_CODE_PROGRAM_EN is defined.
// Rev 1.0
// ----------------------------------------------------------------------------
module lock_sequencer #(
  parameter logic [15:0] CODE           = 16'h4321,
  parameter int          CODE_LEN       = 4,
  parameter int          MAX_ATTEMPTS   = 3,
  parameter int          HOLD_CYCLES    = 10_000_000,
  parameter int          LOCKOUT_CYCLES = 50_000_000
) (
  input logic             clk,
  input logic             rstn,
  lock_sequencer_if.slave bus
);

  localparam logic [15:0] DIGIT_MASK = 16'(32'hFFFF >> (16 - 4 * CODE_LEN));
  localparam logic [1:0]  LAST_IDX   = 2'(CODE_LEN - 1);
  localparam logic [3:0]  MAX_ATT    = 4'(MAX_ATTEMPTS);
  localparam logic [25:0] HOLD_LOAD  = 26'(HOLD_CYCLES - 1);
  localparam logic [25:0] LOCK_LOAD  = 26'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_LOCKOUT = 3'd5
`ifdef LOCK_CODE_PROGRAM_EN
    , ST_PROG  = 3'd6
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] digits, digits_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [3:0]  attempts, attempts_nxt;
  logic [25:0] timer, timer_nxt;
  logic [3:0]  disp_value, disp_value_nxt;
  logic [2:0]  disp_select, disp_select_nxt;
  logic        unlocked_q, unlocked_nxt;
  logic        alarm_q, alarm_nxt;

`ifdef LOCK_CODE_PROGRAM_EN
  logic [15:0] code_reg, code_reg_nxt;
`else
  logic [15:0] code_reg;
  assign code_reg = CODE;
`endif

  // Long press dominates, so a short strobe only counts when long is absent.
  logic short_p, long_p, match, unused_double;
  assign short_p       = bus.pb_press_type[0] & ~bus.pb_press_type[1];
  assign long_p        = bus.pb_press_type[1];
  assign unused_double = bus.pb_press_type[2];
  assign match         = ((digits ^ code_reg) & DIGIT_MASK) == 16'h0000;

  always_comb begin
    state_nxt    = state;
    digits_nxt   = digits;
    idx_nxt      = idx;
    attempts_nxt = attempts;
    timer_nxt    = timer;
`ifdef LOCK_CODE_PROGRAM_EN
    code_reg_nxt = code_reg;
`endif
    case (state)
      ST_IDLE: begin
        if (short_p) begin
          digits_nxt[3:0] = bus.enc;
          if (CODE_LEN == 1) begin
            state_nxt = ST_CHECK;
          end else begin
            idx_nxt   = 2'd1;
            state_nxt = ST_ENTRY;
          end
        end
      end
      ST_ENTRY: begin
        if (long_p) begin
          digits_nxt = 16'h0000;
          idx_nxt    = 2'd0;
          state_nxt  = ST_IDLE;
        end else if (short_p) begin
          digits_nxt[{idx, 2'b00} +: 4] = bus.enc;
          if (idx == LAST_IDX) state_nxt = ST_CHECK;
          else                 idx_nxt   = idx + 2'd1;
        end
      end
      ST_CHECK: begin
        digits_nxt = 16'h0000;
        idx_nxt    = 2'd0;
        if (match) begin
          attempts_nxt = 4'd0;
          state_nxt    = ST_OPEN;
        end else begin
          attempts_nxt = attempts + 4'd1;
          if (attempts_nxt == MAX_ATT) begin
            timer_nxt = LOCK_LOAD;
            state_nxt = ST_LOCKOUT;
          end else begin
            timer_nxt = HOLD_LOAD;
            state_nxt = ST_FAIL;
          end
        end
      end
      ST_FAIL: begin
        if (timer == 26'd0) state_nxt = ST_IDLE;
        else                timer_nxt = timer - 26'd1;
      end
      ST_LOCKOUT: begin
        if (timer == 26'd0) begin
          attempts_nxt = 4'd0;
          state_nxt    = ST_IDLE;
        end else begin
          timer_nxt = timer - 26'd1;
        end
      end
      ST_OPEN: begin
        if (short_p) begin
          state_nxt = ST_IDLE;
`ifdef LOCK_CODE_PROGRAM_EN
        end else if (long_p) begin
          digits_nxt = 16'h0000;
          idx_nxt    = 2'd0;
          state_nxt  = ST_PROG;
`endif
        end
      end
`ifdef LOCK_CODE_PROGRAM_EN
      ST_PROG: begin
        if (long_p) begin
          digits_nxt = 16'h0000;
          idx_nxt    = 2'd0;
          state_nxt  = ST_OPEN;
        end else if (short_p) begin
          digits_nxt[{idx, 2'b00} +: 4] = bus.enc;
          if (idx == LAST_IDX) begin
            code_reg_nxt = digits_nxt;
            idx_nxt      = 2'd0;
            state_nxt    = ST_OPEN;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state; CHECK keeps the last values.
  always_comb begin
    disp_select_nxt = disp_select;
    disp_value_nxt  = disp_value;
    unlocked_nxt    = unlocked_q;
    alarm_nxt       = alarm_q;
    case (state_nxt)
      ST_IDLE: begin
        disp_select_nxt = 3'b000; disp_value_nxt = bus.enc;
        unlocked_nxt    = 1'b0;   alarm_nxt      = 1'b0;
      end
      ST_ENTRY: begin
        disp_select_nxt = {1'b0, idx_nxt}; disp_value_nxt = bus.enc;
        unlocked_nxt    = 1'b0;            alarm_nxt      = 1'b0;
      end
      ST_OPEN: begin
        disp_select_nxt = 3'b100; disp_value_nxt = 4'hA;
        unlocked_nxt    = 1'b1;   alarm_nxt      = 1'b0;
      end
      ST_FAIL: begin
        disp_select_nxt = 3'b101; disp_value_nxt = 4'hF;
        unlocked_nxt    = 1'b0;   alarm_nxt      = 1'b0;
      end
      ST_LOCKOUT: begin
        disp_select_nxt = 3'b110; disp_value_nxt = 4'hE;
        unlocked_nxt    = 1'b0;   alarm_nxt      = 1'b1;
      end
`ifdef LOCK_CODE_PROGRAM_EN
      ST_PROG: begin
        disp_select_nxt = {1'b0, idx_nxt}; disp_value_nxt = bus.enc;
        unlocked_nxt    = 1'b1;            alarm_nxt      = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      digits      <= 16'h0000;
      idx         <= 2'd0;
      attempts    <= 4'd0;
      timer       <= 26'd0;
      disp_value  <= 4'h0;
      disp_select <= 3'b000;
      unlocked_q  <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      digits      <= digits_nxt;
      idx         <= idx_nxt;
      attempts    <= attempts_nxt;
      timer       <= timer_nxt;
      disp_value  <= disp_value_nxt;
      disp_select <= disp_select_nxt;
      unlocked_q  <= unlocked_nxt;
      alarm_q     <= alarm_nxt;
    end
  end

`ifdef LOCK_CODE_PROGRAM_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) code_reg <= CODE;
    else       code_reg <= code_reg_nxt;
  end
`endif

  assign bus.display_value  = disp_value;
  assign bus.display_select = disp_select;
  assign bus.unlocked       = unlocked_q;
  assign bus.alarm          = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lock_sequencer : directed stimulus, per-cycle model comparison, literal pins.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_lock_sequencer;

  localparam int CODE_LEN = 4;
  localparam int MAX_ATT  = 3;
  localparam int HOLD     = 4;
  localparam int LOCKOUT  = 8;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_OPEN = 3,
                 M_HOLD = 4, M_LOCK = 5, M_PROG = 6;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  lock_sequencer_if bus ();

  lock_sequencer #(
    .CODE          (16'h4321),
    .CODE_LEN      (CODE_LEN),
    .MAX_ATTEMPTS  (MAX_ATT),
    .HOLD_CYCLES   (HOLD),
    .LOCKOUT_CYCLES(LOCKOUT)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: entered digits in a queue, cycle countdowns by plain counting.
  int          mode;
  int          digs[$];
  int          fails;
  int          left;
  logic [15:0] mcode;
  logic [3:0]  e_val;
  logic [2:0]  e_sel;
  logic        e_unl, e_alm;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode = M_IDLE; digs.delete(); fails = 0; left = 0; mcode = 16'h4321;
      e_val = 4'h0; e_sel = 3'b000; e_unl = 1'b0; e_alm = 1'b0;
    end else begin
      bit s, l, ok;
      s = bus.pb_press_type[0] && !bus.pb_press_type[1];
      l = bus.pb_press_type[1];
      case (mode)
        M_IDLE, M_ENTRY: begin
          if (l && mode == M_ENTRY) begin
            digs.delete(); mode = M_IDLE;
          end else if (s) begin
            digs.push_back(int'(bus.enc));
            mode = (digs.size() == CODE_LEN) ? M_CHECK : M_ENTRY;
          end
        end
        M_CHECK: begin
          ok = 1'b1;
          for (int i = 0; i < CODE_LEN; i++)
            if (digs[i] != int'(mcode[4*i +: 4])) ok = 1'b0;
          digs.delete();
          if (ok) begin
            fails = 0; mode = M_OPEN;
          end else begin
            fails++;
            if (fails == MAX_ATT) begin mode = M_LOCK; left = LOCKOUT; end
            else                  begin mode = M_HOLD; left = HOLD;    end
          end
        end
        M_HOLD, M_LOCK: begin
          left--;
          if (left == 0) begin
            if (mode == M_LOCK) fails = 0;
            mode = M_IDLE;
          end
        end
        M_OPEN: begin
          if (s) mode = M_IDLE;
`ifdef LOCK_CODE_PROGRAM_EN
          else if (l) begin digs.delete(); mode = M_PROG; end
`endif
        end
        M_PROG: begin
          if (l) begin
            digs.delete(); mode = M_OPEN;
          end else if (s) begin
            digs.push_back(int'(bus.enc));
            if (digs.size() == CODE_LEN) begin
              for (int i = 0; i < CODE_LEN; i++) mcode[4*i +: 4] = 4'(digs[i]);
              digs.delete(); mode = M_OPEN;
            end
          end
        end
        default: mode = M_IDLE;
      endcase
      case (mode)
        M_IDLE:  begin e_sel = 3'b000; e_val = bus.enc; e_unl = 1'b0; e_alm = 1'b0; end
        M_ENTRY: begin e_sel = 3'(digs.size()); e_val = bus.enc; e_unl = 1'b0; e_alm = 1'b0; end
        M_OPEN:  begin e_sel = 3'b100; e_val = 4'hA; e_unl = 1'b1; e_alm = 1'b0; end
        M_HOLD:  begin e_sel = 3'b101; e_val = 4'hF; e_unl = 1'b0; e_alm = 1'b0; end
        M_LOCK:  begin e_sel = 3'b110; e_val = 4'hE; e_unl = 1'b0; e_alm = 1'b1; end
        M_PROG:  begin e_sel = 3'(digs.size()); e_val = bus.enc; e_unl = 1'b1; e_alm = 1'b0; end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && cmp_en) begin
      chk("model display_value",  32'(bus.display_value),  32'(e_val));
      chk("model display_select", 32'(bus.display_select), 32'(e_sel));
      chk("model unlocked",       32'(bus.unlocked),       32'(e_unl));
      chk("model alarm",          32'(bus.alarm),          32'(e_alm));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] v, input logic [2:0] t);
    @(negedge clk);
    bus.enc = v;
    bus.pb_press_type = t;
    @(negedge clk);
    bus.pb_press_type = 3'b000;
  endtask

  task automatic enter4(input logic [3:0] a, b, c, d);
    press(a, 3'b001); press(b, 3'b001); press(c, 3'b001); press(d, 3'b001);
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, " value"},  32'(bus.display_value),  32'h0);
    chk({tag, " select"}, 32'(bus.display_select), 32'h0);
    chk({tag, " unlocked"}, 32'(bus.unlocked),     32'h0);
    chk({tag, " alarm"},  32'(bus.alarm),          32'h0);
  endtask

  int cnt;

  initial begin
    bus.enc = 4'h0;
    bus.pb_press_type = 3'b000;
    #3 outputs_zero("reset");
    idle(3);
    rstn = 1'b1;
    cmp_en = 1'b1;
    idle(2);

    // Correct code, select stepping
    chk("idle select", 32'(bus.display_select), 32'd0);
    press(4'h1, 3'b001); chk("step1 select", 32'(bus.display_select), 32'd1);
    press(4'h2, 3'b001); chk("step2 select", 32'(bus.display_select), 32'd2);
    press(4'h3, 3'b001); chk("step3 select", 32'(bus.display_select), 32'd3);
    press(4'h4, 3'b001); chk("check holds select", 32'(bus.display_select), 32'd3);
    idle(1);
    chk("open unlocked", 32'(bus.unlocked), 32'd1);
    chk("open value", 32'(bus.display_value), 32'hA);

    // Relock
    press(4'h0, 3'b001);
    chk("relock unlocked", 32'(bus.unlocked), 32'd0);

    // Wrong code: hold display exactly HOLD cycles
    enter4(4'h1, 4'h2, 4'h3, 4'h5);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.display_select == 3'b101 && bus.display_value == 4'hF) cnt++;
    end
    chk("hold cycle count", 32'(cnt), 32'd4);
    chk("back to idle select", 32'(bus.display_select), 32'd0);

    // Second and third wrong codes reach lockout; presses ignored during it
    enter4(4'h9, 4'h9, 4'h9, 4'h9);
    idle(6);
    enter4(4'h0, 4'h0, 4'h0, 4'h0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.alarm && bus.display_select == 3'b110) cnt++;
      bus.pb_press_type = (i % 2 == 1 && i < 8) ? 3'b001 : 3'b000;
    end
    chk("lockout cycle count", 32'(cnt), 32'd8);
    chk("post lockout alarm", 32'(bus.alarm), 32'd0);
    chk("post lockout select", 32'(bus.display_select), 32'd0);

    // Attempts cleared by lockout: a single wrong entry only holds
    enter4(4'h5, 4'h5, 4'h5, 4'h5);
    idle(1);
    chk("after lockout wrong select", 32'(bus.display_select), 32'h5);
    chk("after lockout wrong alarm", 32'(bus.alarm), 32'd0);
    idle(5);

    // Abort by long press, long+short together, double ignored
    press(4'h1, 3'b001); press(4'h2, 3'b001);
    press(4'h0, 3'b010);
    chk("long abort select", 32'(bus.display_select), 32'd0);
    press(4'h1, 3'b001);
    press(4'h2, 3'b011);
    chk("long+short select", 32'(bus.display_select), 32'd0);
    press(4'h7, 3'b100);
    chk("double ignored select", 32'(bus.display_select), 32'd0);
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    idle(1);
    chk("reentry open", 32'(bus.unlocked), 32'd1);

`ifdef LOCK_CODE_PROGRAM_EN
    press(4'h0, 3'b010);
    chk("prog select", 32'(bus.display_select), 32'd0);
    chk("prog unlocked", 32'(bus.unlocked), 32'd1);
    enter4(4'h9, 4'h8, 4'h7, 4'h6);
    chk("prog done select", 32'(bus.display_select), 32'h4);
    press(4'h0, 3'b001);
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    idle(1);
    chk("old code rejected", 32'(bus.display_select), 32'h5);
    idle(5);
    enter4(4'h9, 4'h8, 4'h7, 4'h6);
    idle(1);
    chk("new code opens", 32'(bus.unlocked), 32'd1);
`else
    press(4'h0, 3'b010);
    chk("long in open select", 32'(bus.display_select), 32'h4);
    chk("long in open unlocked", 32'(bus.unlocked), 32'd1);
`endif
    press(4'h0, 3'b001);

    // Asynchronous reset mid-entry
    press(4'h1, 3'b001); press(4'h2, 3'b001);
    #2 rstn = 1'b0;
    #1 outputs_zero("async reset");
    @(negedge clk);
    rstn = 1'b1;
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    idle(1);
    chk("post reset default code opens", 32'(bus.unlocked), 32'd1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
